ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 14, word-address width of the shared RAM port (16K x 16-bit).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req0  in  1  requester 0 access request; held high until granted.
REQ-005 we0  in  2  requester 0 byte write enables; 2'b00 = read, [0] = low byte, [1] = high byte.
REQ-006 addr0  in  ADDRESS_WIDTH  requester 0 word address.
REQ-007 wdata0  in  16  requester 0 write data.
REQ-008 gnt0  out  1  requester 0 command accepted this cycle.
REQ-009 rvalid0  out  1  read data for requester 0 valid this cycle.
REQ-010 req1, we1, addr1, wdata1, gnt1, rvalid1: identical to REQ-004..REQ-009, for requester 1.
REQ-011 rdata  out  16  read data, shared by both requesters, qualified by rvalid0/rvalid1.
REQ-012 ram_we  out  2  to RAM port A byte write enables.
REQ-013 ram_addr  out  ADDRESS_WIDTH  to RAM port A address.
REQ-014 ram_data  out  16  to RAM port A write data.
REQ-015 ram_q  in  16  from RAM port A registered read data, valid one cycle after address is presented.

Function
REQ-016 gnt0/gnt1 SHALL be combinational from req0, req1 and the priority pointer; at most one grant per cycle; one command accepted per cycle, with no bubbles.
REQ-017 Only req0 high -> gnt0; only req1 high -> gnt1; neither high -> no grant.
REQ-018 Both high: grant goes to the requester named by the priority pointer (ptr=0 -> requester 0).
REQ-019 ptr SHALL update on every grant to the non-granted requester (round-robin), and SHALL hold when there is no grant.
REQ-020 Stage 1 (cycle N+1 after grant in cycle N): ram_we, ram_addr and ram_data are registered copies of the granted requester's we, addr and wdata.
REQ-021 With no grant in cycle N, ram_we SHALL be 2'b00 in N+1; ram_addr and ram_data hold their previous values.
REQ-022 A read (we==2'b00) granted in cycle N: rvalidX high for exactly cycle N+2, where X is the granted requester; rdata = ram_q in that cycle.
REQ-023 A write granted in cycle N produces no rvalid; ram_we equals the requester's we unmodified in N+1.
REQ-024 Back-to-back grants to alternating requesters SHALL yield the correct rvalid0/rvalid1 sequence, via a 2-deep tag pipeline (valid bit + requester id per stage).
REQ-025 rdata SHALL be driven from ram_q continuously; its value outside rvalid cycles is don't-care.
REQ-026 A read and a write to the same address in consecutive grants: the read returns RAM contents per RAM port A timing (read-before-write within one RAM cycle); the arbiter adds no forwarding.
REQ-027 A request that is not granted SHALL cause no RAM activity and no rvalid.
REQ-028 rvalid0 and rvalid1 SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force: ram_we=2'b00, ram_addr=0, ram_data=0, rvalid0=rvalid1=0, tag pipeline cleared, ptr=0.
REQ-030 gnt0/gnt1 SHALL be 0 while rst_n is low, regardless of req0/req1.
REQ-031 Reads in flight when reset asserts SHALL be discarded; no rvalid after reset deasserts for a command granted before reset.
REQ-032 The first cycle after rst_n deasserts SHALL arbitrate normally, with ptr=0.

Verification
REQ-033 Solo write/read: req0, we0=2'b11, addr0=0x0010, wdata0=0xBEEF; then a read of 0x0010 -> gnt0 each cycle; ram_we=2'b11 one cycle after the first grant; rvalid0 two cycles after the read grant with rdata=0xBEEF; rvalid1 never high.
REQ-034 Contention: req0 and req1 both held high for 4 cycles, reads at 0x0001/0x0002 -> grants alternate 0,1,0,1 starting with requester 0; rvalid pattern identical, delayed by 2 cycles.
REQ-035 Byte enable: write 0x1234 to 0x0020 with we=2'b11, then 0xAB00 with we1=2'b10, then read -> rdata=0xAB34.
REQ-036 Reset mid-read: read granted in cycle N, rst_n low in N+1 for 1 cycle -> rvalid0 stays 0 through N+4; ram_we=0 during reset; next grant goes to requester 0 when both request.
REQ-037 Idle gap: a single req1 read, then 3 idle cycles -> exactly one rvalid1 pulse; ram_we=0 throughout; ptr=0 afterwards (next contention grants requester 0).

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two command ports plus shared read data.
interface ram_arbiter_if #(
  parameter int ADDRESS_WIDTH = 14
);
  logic                     req0;
  logic [1:0]               we0;
  logic [ADDRESS_WIDTH-1:0] addr0;
  logic [15:0]              wdata0;
  logic                     gnt0;
  logic                     rvalid0;

  logic                     req1;
  logic [1:0]               we1;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [15:0]              wdata1;
  logic                     gnt1;
  logic                     rvalid1;

  logic [15:0]              rdata;

  // requester side
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  // arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter onto a single RAM port with registered
// read data. Grants are combinational; the RAM command is registered one
// cycle later and a 2-deep tag pipeline routes read data back to the owner.
module ram_arbiter #(
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ram_arbiter_if.slave             bus,
  output logic [1:0]               ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [15:0]              ram_data,
  input  logic [15:0]              ram_q
);

  logic                     ptr;
  logic                     gnt0;
  logic                     gnt1;
  logic                     any_gnt;
  logic [1:0]               sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [15:0]              sel_data;
  logic                     s1_valid;
  logic                     s1_id;
  logic                     s2_valid;
  logic                     s2_id;

  // Grant: a lone requester always wins; on contention the pointer decides.
  // Grants are gated by rst_n so nothing is accepted while in reset.
  assign gnt0    = rst_n & bus.req0 & (~bus.req1 | ~ptr);
  assign gnt1    = rst_n & bus.req1 & (~bus.req0 | ptr);
  assign any_gnt = gnt0 | gnt1;

  assign sel_we   = gnt1 ? bus.we1    : bus.we0;
  assign sel_addr = gnt1 ? bus.addr1  : bus.addr0;
  assign sel_data = gnt1 ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = s2_valid & ~s2_id;
  assign bus.rvalid1 = s2_valid & s2_id;
  assign bus.rdata   = ram_q;

  // Pointer, RAM command stage and read-tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      ram_we   <= 2'b00;
      ram_addr <= '0;
      ram_data <= '0;
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
    end else begin
      if (gnt0) begin
        ptr <= 1'b1;
      end else if (gnt1) begin
        ptr <= 1'b0;
      end

      // Address/data hold when idle; only the write enables are cleared.
      if (any_gnt) begin
        ram_we   <= sel_we;
        ram_addr <= sel_addr;
        ram_data <= sel_data;
      end else begin
        ram_we <= 2'b00;
      end

      // Stage 1 tracks the command on the RAM pins, stage 2 the cycle its
      // data appears on ram_q.
      s1_valid <= any_gnt & (sel_we == 2'b00);
      s1_id    <= gnt1;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-writable RAM.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ram_we;
  logic [13:0] ram_addr;
  logic [15:0] ram_data;
  logic [15:0] ram_q;
  logic [15:0] mem [0:16383];

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  ram_arbiter_if #(.ADDRESS_WIDTH(14)) bus ();

  ram_arbiter #(.ADDRESS_WIDTH(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port A: registered read, old data returned when read and write collide.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_data[7:0];
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_data[15:8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic [1:0] w, input logic [13:0] a, input logic [15:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic [1:0] w, input logic [13:0] a, input logic [15:0] d);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  // The two read-valid strobes must never coincide.
  always @(negedge clk) begin
    chk("rv_excl", 32'(bus.rvalid0 & bus.rvalid1), 0);
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    rst_n = 1'b0;
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    step();

    // reset state, grants blocked even with both requesting
    drive0(1'b1, 2'b00, 14'h0, 16'h0);
    drive1(1'b1, 2'b00, 14'h0, 16'h0);
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 0);
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    step();
    rst_n = 1'b1;

    // solo write then read
    drive0(1'b1, 2'b11, 14'h0010, 16'hBEEF);
    #1;
    chk("solo_wr_gnt0", 32'(bus.gnt0), 1);
    chk("solo_wr_gnt1", 32'(bus.gnt1), 0);
    step();
    chk("solo_ram_we", 32'(ram_we), 3);
    chk("solo_ram_addr", 32'(ram_addr), 32'h10);
    chk("solo_ram_data", 32'(ram_data), 32'hBEEF);
    drive0(1'b1, 2'b00, 14'h0010, 16'h0);
    #1;
    chk("solo_rd_gnt0", 32'(bus.gnt0), 1);
    step();
    chk("solo_rd_ram_we", 32'(ram_we), 0);
    chk("solo_wr_no_rv", 32'(bus.rvalid0), 0);
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    step();
    chk("solo_rvalid0", 32'(bus.rvalid0), 1);
    chk("solo_rvalid1", 32'(bus.rvalid1), 0);
    chk("solo_rdata", 32'(bus.rdata), 32'hBEEF);
    step();
    chk("solo_rv_end", 32'(bus.rvalid0), 0);

    // contention, after a reset pulse away from the clock edge
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive0(1'b1, 2'b00, 14'h0001, 16'h0);
    drive1(1'b1, 2'b00, 14'h0002, 16'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
        chk("cont_gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
        chk("cont_gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
      end
      if (i >= 2) begin
        chk("cont_rvalid0", 32'(bus.rvalid0), 32'(i % 2 == 0));
        chk("cont_rvalid1", 32'(bus.rvalid1), 32'(i % 2 == 1));
        chk("cont_rdata", 32'(bus.rdata), (i % 2 == 0) ? 32'h1111 : 32'h2222);
      end
      step();
      if (i == 3) begin
        drive0(1'b0, 2'b00, 14'h0, 16'h0);
        drive1(1'b0, 2'b00, 14'h0, 16'h0);
      end
    end
    chk("cont_idle_rv0", 32'(bus.rvalid0), 0);
    chk("cont_idle_rv1", 32'(bus.rvalid1), 0);

    // byte enables
    drive0(1'b1, 2'b11, 14'h0020, 16'h1234);
    #1;
    chk("be_gnt0", 32'(bus.gnt0), 1);
    step();
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    drive1(1'b1, 2'b10, 14'h0020, 16'hAB00);
    #1;
    chk("be_gnt1_wr", 32'(bus.gnt1), 1);
    step();
    chk("be_ram_we", 32'(ram_we), 2);
    drive1(1'b1, 2'b00, 14'h0020, 16'h0);
    #1;
    chk("be_gnt1_rd", 32'(bus.gnt1), 1);
    step();
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    step();
    chk("be_rvalid1", 32'(bus.rvalid1), 1);
    chk("be_rdata", 32'(bus.rdata), 32'hAB34);

    // read then write to the same address: read sees old contents
    drive0(1'b1, 2'b00, 14'h0020, 16'h0);
    #1;
    chk("raw_rd_gnt0", 32'(bus.gnt0), 1);
    step();
    drive0(1'b1, 2'b11, 14'h0020, 16'h5555);
    #1;
    chk("raw_wr_gnt0", 32'(bus.gnt0), 1);
    step();
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    chk("raw_rvalid0", 32'(bus.rvalid0), 1);
    chk("raw_rdata", 32'(bus.rdata), 32'hAB34);
    step();
    chk("raw_rv_end", 32'(bus.rvalid0), 0);

    // reset with a read in flight
    drive0(1'b1, 2'b00, 14'h0001, 16'h0);
    #1;
    chk("rmr_gnt0", 32'(bus.gnt0), 1);
    step();
    rst_n = 1'b0;
    drive0(1'b1, 2'b11, 14'h0030, 16'h0A0A);
    drive1(1'b1, 2'b11, 14'h0031, 16'h0B0B);
    #1;
    chk("rmr_gnt0_inrst", 32'(bus.gnt0), 0);
    chk("rmr_gnt1_inrst", 32'(bus.gnt1), 0);
    chk("rmr_ram_we", 32'(ram_we), 0);
    chk("rmr_rv0_n1", 32'(bus.rvalid0), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rmr_rv0_n2", 32'(bus.rvalid0), 0);
    chk("rmr_post_gnt0", 32'(bus.gnt0), 1);
    chk("rmr_post_gnt1", 32'(bus.gnt1), 0);
    step();
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    chk("rmr_rv0_n3", 32'(bus.rvalid0), 0);
    chk("rmr_wr_ram_we", 32'(ram_we), 3);
    step();
    chk("rmr_rv0_n4", 32'(bus.rvalid0), 0);

    // single req1 read followed by an idle gap
    drive1(1'b1, 2'b00, 14'h0002, 16'h0);
    #1;
    chk("idle_gnt1", 32'(bus.gnt1), 1);
    step();
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_ram_we", 32'(ram_we), 0);
      if (bus.rvalid1) pulses++;
      step();
    end
    chk("idle_pulses", 32'(pulses), 1);
    drive0(1'b1, 2'b00, 14'h0001, 16'h0);
    drive1(1'b1, 2'b00, 14'h0002, 16'h0);
    #1;
    chk("idle_next_gnt0", 32'(bus.gnt0), 1);
    chk("idle_next_gnt1", 32'(bus.gnt1), 0);
    step();
    drive0(1'b0, 2'b00, 14'h0, 16'h0);
    drive1(1'b0, 2'b00, 14'h0, 16'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
